anf_degree_scan: RTL

Sequential post-processor sitting directly downstream of the clocked Möbius transform stage. It takes the N-bit algebraic normal form (ANF) vector that the transform produces after log2_N rounds and scans it LANES coefficients per cycle. It reports the algebraic degree, the number of monomials (ANF weight) and a zero-function flag. It uses a start/busy/done handshake so that the transform output can be sampled once and then released.

---
 rtl/anf_degree_scan.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/anf_degree_scan.sv
// ANF degree / weight scanner.
// Snapshots an N-coefficient algebraic normal form vector on start, then walks
// it LANES coefficients per cycle, tracking the highest monomial degree seen
// and the number of monomials. The results are published with a one-cycle
// done pulse and held until the next scan completes or reset.
module anf_degree_scan #(
  parameter int N      = 1024,
  parameter int LOG2_N = 10,
  parameter int LANES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:N-1]      anf,
  output logic              busy,
  output logic              done,
  output logic [LOG2_N:0]   degree,
  output logic [LOG2_N:0]   weight,
  output logic              zero_fn
);

  localparam int W   = LOG2_N + 1;
  localparam int NCH = N / LANES;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [0:N-1]      snap_q, snap_d;
  logic [CW-1:0]     c_q, c_d;
  logic [W-1:0]      max_q, max_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [W-1:0]      degree_q, degree_d;
  logic [W-1:0]      weight_q, weight_d;
  logic              zero_q, zero_d;

  logic [W-1:0]      chunk_sum;
  logic [W-1:0]      chunk_max;
  logic [LOG2_N-1:0] idx;
  logic [W-1:0]      pc;
  logic [W-1:0]      sum_n;
  logic [W-1:0]      max_n;

  // Number of variables in the monomial addressed by a coefficient index.
  function automatic logic [W-1:0] popcount(input logic [LOG2_N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2_N; b++) r = r + W'(v[b]);
    return r;
  endfunction

  // Reduce the current chunk of the snapshot to its set-bit count and its
  // highest monomial degree.
  always_comb begin
    chunk_sum = '0;
    chunk_max = '0;
    idx       = '0;
    pc        = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = LOG2_N'(int'(c_q) * LANES + l);
      if (snap_q[idx]) begin
        chunk_sum = chunk_sum + W'(1);
        pc        = popcount(idx);
        if (pc > chunk_max) chunk_max = pc;
      end
    end
  end

  // Running totals including the chunk under examination this cycle.
  always_comb begin
    sum_n = sum_q + chunk_sum;
    max_n = (chunk_max > max_q) ? chunk_max : max_q;
  end

  // Next-state logic: start is only honoured outside SCAN, so a scan in
  // progress can never be restarted or have its snapshot overwritten.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    c_d      = c_q;
    max_d    = max_q;
    sum_d    = sum_q;
    degree_d = degree_q;
    weight_d = weight_q;
    zero_d   = zero_q;
    case (state_q)
      SCAN: begin
        sum_d = sum_n;
        max_d = max_n;
        c_d   = c_q + CW'(1);
        if (c_q == LAST_CHUNK) begin
          degree_d = max_n;
          weight_d = sum_n;
          zero_d   = (sum_n == '0);
          state_d  = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back scans.
        if (start) begin
          snap_d  = anf;
          c_d     = '0;
          max_d   = '0;
          sum_d   = '0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and result registers; the snapshot and running totals are always
  // re-initialised by start, so only control and published results reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    max_q  <= max_d;
    sum_q  <= sum_d;
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      degree_q <= '0;
      weight_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      degree_q <= degree_d;
      weight_q <= weight_d;
      zero_q   <= zero_d;
    end
  end

  assign busy    = (state_q == SCAN);
  assign done    = (state_q == DONE);
  assign degree  = degree_q;
  assign weight  = weight_q;
  assign zero_fn = zero_q;

endmodule
